// File: rtl/muldiv_unit.sv
// Iterative multiply/divide: one result bit per cycle, then a one-cycle sign fix.
// Define MULDIV_SIGNED_EN to make op[0] select signed MULT/DIV.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic               is_div_q, is_div_d;
    logic               neg_a_q, neg_a_d;
    logic               neg_b_q, neg_b_d;
    logic               bz_q, bz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               dbz_q, dbz_d;

    logic load, step, commit;
    logic sgn, neg_a, neg_b;
    logic [WIDTH-1:0] mag_a, mag_b;

`ifdef MULDIV_SIGNED_EN
    assign sgn = op[0];
`else
    logic unused_op0;
    assign unused_op0 = op[0];
    assign sgn        = 1'b0;
`endif

    assign neg_a = sgn & a[WIDTH-1];
    assign neg_b = sgn & b[WIDTH-1];
    assign mag_a = neg_a ? -a : a;
    assign mag_b = neg_b ? -b : b;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = CALC;
                    load    = 1'b1;
                end
            end
            CALC: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    commit  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start && !abort) begin
                    state_d = CALC;
                    load    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Multiply: add multiplicand into upper half on lsb, then shift right.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_nxt;
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    assign mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: remainder in upper half, dividend shifts out / quotient in.
    logic [WIDTH:0]     div_shl;
    logic               div_ge;
    logic [WIDTH-1:0]   div_sub;
    logic [2*WIDTH-1:0] div_nxt;
    assign div_shl = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge  = div_shl >= {1'b0, opnd_q};
    assign div_sub = div_shl[WIDTH-1:0] - opnd_q;
    assign div_nxt = div_ge
                   ? {div_sub, acc_q[WIDTH-2:0], 1'b1}
                   : {div_shl[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

    logic               flip;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    assign flip     = neg_a_q ^ neg_b_q;
    assign prod_fix = flip ? -acc_q : acc_q;
    assign quo_fix  = flip ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH]
                              : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        a_d      = a_q;
        is_div_d = is_div_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        bz_d     = bz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = dbz_q;
        if (load) begin
            cnt_d    = '0;
            is_div_d = op[1];
            neg_a_d  = neg_a;
            neg_b_d  = neg_b;
            a_d      = a;
            bz_d     = op[1] & (b == '0);
            opnd_d   = op[1] ? mag_b : mag_a;
            acc_d    = {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
        end
        if (step) begin
            cnt_d = cnt_q + CW'(1);
            acc_d = is_div_q ? div_nxt : mul_nxt;
        end
        if (commit) begin
            dbz_d = bz_q;
            if (!is_div_q) begin
                {hi_d, lo_d} = prod_fix;
            end else if (bz_q) begin
                hi_d = a_q;
                lo_d = '1;
            end else begin
                hi_d = rem_fix;
                lo_d = quo_fix;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            a_q      <= '0;
            is_div_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            bz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            a_q      <= a_d;
            is_div_q <= is_div_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            bz_q     <= bz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = (state_q == CALC) || (state_q == FIX);
    assign done        = (state_q == DONE);
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at WIDTH = 32; expectations follow
// MULDIV_SIGNED_EN when it is defined for the build.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         abort;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;

    int n_vec = 0;
    int n_err = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (dbz)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Edge e counts from the accepting edge (edge 0); the value sampled
    // just before edge e is what the task records for edge e.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input bit disturb,
                          output int de, output int berr, output int dc);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        de = 0; berr = 0; dc = 0;
        for (int e = 1; e <= W + 6; e++) begin
            if (busy !== (e <= W + 1)) berr++;
            if (done === 1'b1) begin
                dc++;
                if (de == 0) de = e;
            end
            if (disturb && e == 3) begin
                op = 2'b00; a = 32'h5; b = 32'h1; start = 1'b1;
            end
            if (disturb && e == 7) start = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        n_vec++; if (hi !== 32'h0) begin n_err++; $display("FAIL reset_hi got %h want 0", hi); end
        n_vec++; if (lo !== 32'h0) begin n_err++; $display("FAIL reset_lo got %h want 0", lo); end
        n_vec++; if (dbz !== 1'b0) begin n_err++; $display("FAIL reset_dbz got %b want 0", dbz); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_multu_max;
        int de, be, dc;
        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, de, be, dc);
        n_vec++; if (de != 34) begin n_err++; $display("FAIL multu_done_edge got %0d want 34", de); end
        n_vec++; if (be != 0) begin n_err++; $display("FAIL multu_busy_profile got %0d bad cycles want 0", be); end
        n_vec++; if (dc != 1) begin n_err++; $display("FAIL multu_done_pulses got %0d want 1", dc); end
        n_vec++; if (hi !== 32'hFFFFFFFE) begin n_err++; $display("FAIL multu_hi got %h want fffffffe", hi); end
        n_vec++; if (lo !== 32'h00000001) begin n_err++; $display("FAIL multu_lo got %h want 00000001", lo); end
        n_vec++; if (dbz !== 1'b0) begin n_err++; $display("FAIL multu_dbz got %b want 0", dbz); end
    endtask

    task automatic test_mult_signed;
        int de, be, dc;
        logic [W-1:0] eh;
`ifdef MULDIV_SIGNED_EN
        eh = 32'hFFFFFFFF;
`else
        eh = 32'h00000004;
`endif
        run_op(2'b01, 32'hFFFFFFFD, 32'h5, 1'b0, de, be, dc);
        n_vec++; if (hi !== eh) begin n_err++; $display("FAIL mult_hi got %h want %h", hi, eh); end
        n_vec++; if (lo !== 32'hFFFFFFF1) begin n_err++; $display("FAIL mult_lo got %h want fffffff1", lo); end
        n_vec++; if (de != 34) begin n_err++; $display("FAIL mult_done_edge got %0d want 34", de); end
    endtask

    task automatic test_div_signed;
        int de, be, dc;
        logic [W-1:0] eh1, el1, eh2, el2;
`ifdef MULDIV_SIGNED_EN
        eh1 = 32'hFFFFFFFF; el1 = 32'hFFFFFFFD;
        eh2 = 32'h00000000; el2 = 32'h80000000;
`else
        eh1 = 32'h00000001; el1 = 32'h7FFFFFFC;
        eh2 = 32'h80000000; el2 = 32'h00000000;
`endif
        run_op(2'b11, 32'hFFFFFFF9, 32'h2, 1'b0, de, be, dc);
        n_vec++; if (lo !== el1) begin n_err++; $display("FAIL div_m7_lo got %h want %h", lo, el1); end
        n_vec++; if (hi !== eh1) begin n_err++; $display("FAIL div_m7_hi got %h want %h", hi, eh1); end
        run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b0, de, be, dc);
        n_vec++; if (lo !== el2) begin n_err++; $display("FAIL div_min_lo got %h want %h", lo, el2); end
        n_vec++; if (hi !== eh2) begin n_err++; $display("FAIL div_min_hi got %h want %h", hi, eh2); end
        n_vec++; if (dbz !== 1'b0) begin n_err++; $display("FAIL div_min_dbz got %b want 0", dbz); end
    endtask

    task automatic test_div_zero;
        int de, be, dc;
        run_op(2'b10, 32'd100, 32'd0, 1'b0, de, be, dc);
        n_vec++; if (dbz !== 1'b1) begin n_err++; $display("FAIL dz_flag got %b want 1", dbz); end
        n_vec++; if (hi !== 32'h64) begin n_err++; $display("FAIL dz_hi got %h want 00000064", hi); end
        n_vec++; if (lo !== 32'hFFFFFFFF) begin n_err++; $display("FAIL dz_lo got %h want ffffffff", lo); end
        n_vec++; if (de != 34) begin n_err++; $display("FAIL dz_done_edge got %0d want 34", de); end
        run_op(2'b00, 32'd2, 32'd3, 1'b0, de, be, dc);
        n_vec++; if (dbz !== 1'b0) begin n_err++; $display("FAIL dz_clear got %b want 0", dbz); end
        n_vec++; if (lo !== 32'd6) begin n_err++; $display("FAIL mul23_lo got %h want 00000006", lo); end
        n_vec++; if (hi !== 32'd0) begin n_err++; $display("FAIL mul23_hi got %h want 0", hi); end
    endtask

    task automatic test_abort;
        int dc, bc;
        @(negedge clk);
        op = 2'b10; a = 32'd10; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b want 0", busy); end
        dc = 0; bc = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) dc++;
            if (busy === 1'b1) bc++;
            @(posedge clk); #1;
        end
        n_vec++; if (dc != 0) begin n_err++; $display("FAIL abort_no_done got %0d pulses want 0", dc); end
        n_vec++; if (bc != 0) begin n_err++; $display("FAIL abort_idle got %0d busy cycles want 0", bc); end
        n_vec++; if (hi !== 32'd0) begin n_err++; $display("FAIL abort_hi got %h want 0", hi); end
        n_vec++; if (lo !== 32'd6) begin n_err++; $display("FAIL abort_lo got %h want 00000006", lo); end
    endtask

    task automatic test_operand_change;
        int de, be, dc;
        run_op(2'b10, 32'd100, 32'd7, 1'b1, de, be, dc);
        n_vec++; if (lo !== 32'd14) begin n_err++; $display("FAIL hold_lo got %h want 0000000e", lo); end
        n_vec++; if (hi !== 32'd2) begin n_err++; $display("FAIL hold_hi got %h want 00000002", hi); end
        n_vec++; if (de != 34 || dc != 1) begin
            n_err++; $display("FAIL hold_done got edge %0d pulses %0d want 34/1", de, dc);
        end
    endtask

    task automatic test_rst_mid;
        int dc, bc;
        bit got;
        @(negedge clk);
        op = 2'b10; a = 32'd10; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_vec++; if ({busy, done, dbz} !== 3'b000) begin
            n_err++; $display("FAIL rst_mid_flags got %b want 000", {busy, done, dbz});
        end
        n_vec++; if (hi !== 32'd0 || lo !== 32'd0) begin
            n_err++; $display("FAIL rst_mid_data got %h_%h want 0_0", hi, lo);
        end
        @(negedge clk);
        rst = 1'b0;
        dc = 0; bc = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) dc++;
            if (busy === 1'b1) bc++;
        end
        n_vec++; if (dc != 0 || bc != 0) begin
            n_err++; $display("FAIL rst_discard got %0d done %0d busy want 0/0", dc, bc);
        end
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; op = 2'b00; a = 32'd7; b = 32'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_first_start got busy %b want 1", busy); end
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) begin got = 1'b1; break; end
            @(posedge clk); #1;
        end
        n_vec++; if (!got || lo !== 32'd42) begin
            n_err++; $display("FAIL rst_first_result got done %b lo %h want 1/0000002a", got, lo);
        end
    endtask

    task automatic test_back_to_back;
        int de, dc;
        bit got;
        @(negedge clk);
        op = 2'b10; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        got = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            if (done === 1'b1) begin got = 1'b1; break; end
            @(posedge clk); #1;
        end
        n_vec++; if (!got || lo !== 32'd14 || hi !== 32'd2) begin
            n_err++; $display("FAIL b2b_first got done %b %h_%h want 1 00000002_0000000e", got, hi, lo);
        end
        op = 2'b00; a = 32'd9; b = 32'd11; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_vec++; if (busy !== 1'b1 || done !== 1'b0) begin
            n_err++; $display("FAIL b2b_no_gap got busy %b done %b want 1/0", busy, done);
        end
        de = 0; dc = 0;
        for (int e = 1; e <= W + 6; e++) begin
            if (done === 1'b1) begin
                dc++;
                if (de == 0) de = e;
            end
            @(posedge clk); #1;
        end
        n_vec++; if (de != 34 || dc != 1) begin
            n_err++; $display("FAIL b2b_second_done got edge %0d pulses %0d want 34/1", de, dc);
        end
        n_vec++; if (lo !== 32'd99 || hi !== 32'd0) begin
            n_err++; $display("FAIL b2b_second got %h_%h want 00000000_00000063", hi, lo);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        op = 2'b00; a = '0; b = '0;
        test_reset;
        test_multu_max;
        test_mult_signed;
        test_div_signed;
        test_div_zero;
        test_abort;
        test_operand_change;
        test_rst_mid;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high, with ports named clk and rst.
REQ-002 Parameter WIDTH, default 32: operand width in bits; legal values are even numbers from 8 to 64.
REQ-003 Port clk, input, 1 bit: clock; all state changes on the rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-005 Port start, input, 1 bit: request a new operation.
REQ-006 Port op, input, 2 bits: operation select. 00 = MULTU, 01 = MULT, 10 = DIVU, 11 = DIV.
REQ-007 Port a, input, WIDTH bits: multiplicand or dividend.
REQ-008 Port b, input, WIDTH bits: multiplier or divisor.
REQ-009 Port abort, input, 1 bit: synchronous cancel of an operation in flight.
REQ-010 Port busy, output, 1 bit: an operation is in progress.
REQ-011 Port done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-012 Port hi, output, WIDTH bits: product upper half, or remainder.
REQ-013 Port lo, output, WIDTH bits: product lower half, or quotient.
REQ-014 Port div_by_zero, output, 1 bit: the last division had b == 0.

Function
REQ-015 The block SHALL implement the states IDLE, CALC, FIX and DONE.
REQ-016 start SHALL be accepted only in IDLE or DONE; an accepted start latches op, a and b and moves to CALC.
REQ-017 start in CALC or FIX SHALL be ignored; changes on a, b and op while busy SHALL NOT affect the result.
REQ-018 CALC SHALL last exactly WIDTH cycles, one bit per cycle: shift-add for multiply, restoring shift-subtract for divide, on operand magnitudes.
REQ-019 FIX SHALL last one cycle and apply sign correction:
  - product negated if the operand signs differ;
  - quotient negated if the operand signs differ;
  - remainder takes the dividend sign.
REQ-020 done SHALL be high for exactly one cycle, in DONE, at the (WIDTH+2)th rising edge after the accepting edge.
REQ-021 hi, lo and div_by_zero SHALL update only on entry to DONE, and hold until the next DONE or reset.
REQ-022 busy SHALL be high in CALC and FIX and low in IDLE and DONE.
REQ-023 Without a new start, DONE SHALL return to IDLE after one cycle; with a start in DONE, the next operation begins back-to-back.
REQ-024 Multiply SHALL produce the full 2*WIDTH-bit product, with hi = upper and lo = lower.
REQ-025 Divide by zero SHALL complete with the normal latency and set hi = a, lo = all ones, div_by_zero = 1.
REQ-026 div_by_zero SHALL be 0 after any multiply or any division with b != 0.
REQ-027 Signed DIV of the most-negative value by -1 SHALL give lo = most-negative and hi = 0, with no flag.
REQ-028 abort in CALC or FIX SHALL return the block to IDLE at the next edge with hi, lo and div_by_zero unchanged and no done pulse.
REQ-029 abort SHALL have priority over start; abort in IDLE or DONE SHALL be ignored, except that a same-cycle start is dropped.

Reset
REQ-030 rst SHALL immediately force state IDLE, busy = 0, done = 0, hi = 0, lo = 0, div_by_zero = 0, and clear the internal accumulators.
REQ-031 rst asserted mid-operation SHALL discard that operation; no done pulse SHALL follow the deassertion of rst.
REQ-032 The first start after rst deasserts SHALL be accepted on the first rising edge at which rst is low.

Configuration
REQ-033 Macro MULDIV_SIGNED_EN, when defined, SHALL make op[0] = 1 select signed MULT and DIV as specified above.
REQ-034 When MULDIV_SIGNED_EN is undefined, op[0] SHALL be ignored, all operations SHALL be unsigned, and the FIX state SHALL still occupy one cycle so that latency is unchanged.

Verification (WIDTH = 32, MULDIV_SIGNED_EN defined unless noted)
REQ-035 MULTU 0xFFFFFFFF * 0xFFFFFFFF -> done at edge 34 after accept, hi = 0xFFFFFFFE, lo = 0x00000001, busy high for edges 1-33.
REQ-036 MULT -3 * 5 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFF1; the same stimulus with the macro undefined -> hi = 0x00000004, lo = 0xFFFFFFF1.
REQ-037 DIV -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
REQ-037a DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
REQ-038 DIVU 100 / 0 -> div_by_zero = 1, hi = 0x00000064, lo = 0xFFFFFFFF.
REQ-038a The next operation, MULTU 2 * 3 -> div_by_zero = 0, lo = 6.
REQ-039 Start DIVU 10 / 3, then assert abort at edge 5 -> IDLE, no done, hi/lo keep prior values.
REQ-039a Start DIVU 10 / 3, then assert rst at edge 10 -> all outputs 0 and no done.
REQ-040 Back-to-back: start held in DONE -> second op accepted with no idle cycle; both results correct; exactly one done pulse per operation.
